// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined 4-bit-group carry-lookahead adder/subtractor with valid/ready
module pipelined_cla_addsub #(
    parameter int WIDTH = 16,
    parameter int GPS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int SW     = 4 * GPS;
    localparam int STAGES = WIDTH / SW;

    // Full lookahead inside one 4-bit group; returns carries into bits 1..3 and the group carry-out.
    function automatic logic [4:1] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic [4:1] c;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic              advance;
    logic [WIDTH-1:0]  ia   [STAGES];
    logic [WIDTH-1:0]  ib   [STAGES];
    logic [WIDTH-1:0]  isum [STAGES];
    logic [WIDTH-1:0]  nsum [STAGES];
    logic [STAGES-1:0] ic, iv, nc;
    logic              novf, nzero;

    logic [WIDTH-1:0]  ra   [STAGES];
    logic [WIDTH-1:0]  rb   [STAGES];
    logic [WIDTH-1:0]  rsum [STAGES];
    logic [STAGES-1:0] rc, rv;
    logic              rovf, rzero;

    assign advance   = !rv[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = rv[STAGES-1];
    assign out_sum   = rsum[STAGES-1];
    assign out_cout  = rc[STAGES-1];
    assign out_ovf   = rovf;
    assign out_zero  = rzero;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0] sa, sb, sp, sg, bc, ss;
        logic [GPS:0]  gc;

        // Operand b is inverted once on entry; later stages see the already-inverted copy.
        if (k == 0) begin : g_first
            assign ia[k]   = in_a;
            assign ib[k]   = in_sub ? ~in_b : in_b;
            assign ic[k]   = in_sub | in_cin;
            assign iv[k]   = in_valid;
            assign isum[k] = '0;
        end else begin : g_next
            assign ia[k]   = ra[k-1];
            assign ib[k]   = rb[k-1];
            assign ic[k]   = rc[k-1];
            assign iv[k]   = rv[k-1];
            assign isum[k] = rsum[k-1];
        end

        assign sa    = ia[k][SW*k +: SW];
        assign sb    = ib[k][SW*k +: SW];
        assign sp    = sa ^ sb;
        assign sg    = sa & sb;
        assign gc[0] = ic[k];

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            logic [4:1] c;
            assign c              = cla4(sg[4*j +: 4], sp[4*j +: 4], gc[j]);
            assign bc[4*j +: 4]   = {c[3:1], gc[j]};
            assign gc[j+1]        = c[4];
        end

        assign ss      = sp ^ bc;
        assign nsum[k] = isum[k] | (WIDTH'(ss) << (SW * k));
        assign nc[k]   = gc[GPS];

        if (k == STAGES - 1) begin : g_last
            assign novf  = bc[SW-1] ^ gc[GPS];
            assign nzero = (nsum[k] == '0);
        end
    end

    // The whole pipe advances or freezes as a single unit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ra[k]   <= '0;
                rb[k]   <= '0;
                rsum[k] <= '0;
            end
            rc    <= '0;
            rv    <= '0;
            rovf  <= 1'b0;
            rzero <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                ra[k]   <= ia[k];
                rb[k]   <= ib[k];
                rsum[k] <= nsum[k];
            end
            rc    <= nc;
            rv    <= iv;
            rovf  <= novf;
            rzero <= nzero;
        end
    end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - self-checking bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;
    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] sum;
        logic        cout, ovf, zero;
    } vec_t;

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        logic [31:0] sum;
        logic        cout, ovf, zero;
    } vec32_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_cin, in_sub;
    logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [15:0] in_a, in_b, out_sum;

    logic        s_valid, s_cin, s_sub;
    logic [31:0] s_a, s_b;
    logic [2:0]  w_valid, w_rdy, w_cout, w_ovf, w_zero;
    logic [31:0] w_sum [3];

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t cur_exp;
    exp_t got;
    int   run = 0;
    int   max_run = 0;
    logic held = 1'b0;
    logic [18:0] held_val;
    logic bp_mode = 1'b0;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(.WIDTH(16), .GPS(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    for (genvar i = 0; i < 3; i++) begin : g_sw
        pipelined_cla_addsub #(.WIDTH(32), .GPS(i == 0 ? 1 : (i == 1 ? 2 : 8))) u (
            .clk(clk), .rst_n(rst_n),
            .in_valid(s_valid), .in_ready(w_rdy[i]),
            .in_a(s_a), .in_b(s_b), .in_cin(s_cin), .in_sub(s_sub),
            .out_valid(w_valid[i]), .out_ready(1'b1),
            .out_sum(w_sum[i]), .out_cout(w_cout[i]), .out_ovf(w_ovf[i]), .out_zero(w_zero[i])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        logic [15:0] bb;
        logic [16:0] full;
        exp_t        e;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + 17'(sub ? 1'b1 : cin);
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (a[15] == bb[15]) && (e.sum[15] != a[15]);
        e.zero = (e.sum == 16'h0000);
        return e;
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input exp_t e);
        int   n;
        logic acc;
        n        = 0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        cur_exp  = e;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 100);
        if (!acc) check("accept_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drive_rand();
        logic [15:0] a, b;
        logic        cin, sub;
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        drive(a, b, cin, sub, model(a, b, cin, sub));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: decisions taken mid-cycle describe what the next rising edge does.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            run  = 0;
            held = 1'b0;
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (held)
                check("stall_hold", {out_valid, out_sum, out_cout, out_ovf, out_zero}, {1'b1, held_val});
            held     = out_valid && !out_ready;
            held_val = {out_sum, out_cout, out_ovf, out_zero};
            if (out_valid && out_ready) begin
                run++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got sum %0h with no beat outstanding", out_sum);
                end else begin
                    got = sb.pop_front();
                    check("sum", out_sum, got.sum);
                    check("flags", {out_cout, out_ovf, out_zero}, {got.cout, got.ovf, got.zero});
                end
            end else begin
                run = 0;
            end
            if (run > max_run) max_run = run;
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t   vt [7];
        vec32_t wt [6];
        exp_t   e;
        int     lat;
        int     got_lat [3];
        int     exp_lat [3];

        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vt[2] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        vt[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vt[4] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vt[5] = '{16'h5A5A, 16'h5A5A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[6] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};

        wt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        wt[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        wt[2] = '{32'h1234_1234, 32'h4321_4321, 1'b1, 1'b0, 32'h5555_5556, 1'b0, 1'b0, 1'b0};
        wt[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        wt[4] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        wt[5] = '{32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        exp_lat = '{8, 4, 1};

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 16'($urandom);
        in_b      = 16'($urandom);
        in_cin    = 1'b1;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        s_valid   = 1'b0;
        s_a       = '0;
        s_b       = '0;
        s_cin     = 1'b0;
        s_sub     = 1'b0;
        cur_exp   = '0;

        // Reset held with live traffic on the inputs
        repeat (3) begin
            @(posedge clk);
            #1;
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_outputs", {out_sum, out_cout, out_ovf, out_zero}, 19'h0);
            check("rst_in_ready", in_ready, 1'b1);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // First post-reset beat: latency, then the rest of the corner table
        e   = '{vt[0].sum, vt[0].cout, vt[0].ovf, vt[0].zero};
        drive(vt[0].a, vt[0].b, vt[0].cin, vt[0].sub, e);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency16", lat, 4);
        for (int i = 1; i < 7; i++) begin
            e = '{vt[i].sum, vt[i].cout, vt[i].ovf, vt[i].zero};
            drive(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, e);
        end
        drain();

        // Back-to-back streaming at full rate
        max_run = 0;
        for (int i = 0; i < 1000; i++) drive_rand();
        drain();
        check("stream_run", max_run, 1000);

        // Random backpressure and random input gaps
        bp_mode = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 1) drive_rand();
            else begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bp_mode   = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) drive_rand();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("midreset_no_deliver", out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        check("midreset_queue", sb.size(), 0);
        e = '{vt[3].sum, vt[3].cout, vt[3].ovf, vt[3].zero};
        drive(vt[3].a, vt[3].b, vt[3].cin, vt[3].sub, e);
        drain();

        // 32-bit corners across group-per-stage settings
        for (int i = 0; i < 6; i++) begin
            s_a     = wt[i].a;
            s_b     = wt[i].b;
            s_cin   = wt[i].cin;
            s_sub   = wt[i].sub;
            s_valid = 1'b1;
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            got_lat = '{0, 0, 0};
            for (int l = 1; l <= 10; l++) begin
                for (int d = 0; d < 3; d++) begin
                    if (w_valid[d] && got_lat[d] == 0) begin
                        got_lat[d] = l;
                        check("w32_sum", w_sum[d], wt[i].sum);
                        check("w32_flags", {w_cout[d], w_ovf[d], w_zero[d]},
                              {wt[i].cout, wt[i].ovf, wt[i].zero});
                    end
                end
                @(posedge clk);
                #1;
            end
            for (int d = 0; d < 3; d++) check("w32_latency", got_lat[d], exp_lat[d]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
